// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory port arbiter slice.
//   - arb_state_t : arbiter FSM states
//   - SZ_B/SZ_H/SZ_W : load/store size codes (code 2'b11 behaves as a word)
//   - NB_* : number of byte-memory beats per access size
//   - byte_count(): maps a size code onto its beat count
// No ports; imported by the interface users and the arbiter itself.
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } arb_state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    // Beat count for a size code; the reserved code falls through to a word.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        case (size)
            SZ_B:    byte_count = NB_BYTE;
            SZ_H:    byte_count = NB_HALF;
            default: byte_count = NB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the two requester ports (fetch "if_*" and load/store "ls_*"), the
// byte-wide memory port ("mem_*") and the busy flag of the arbiter.
//   modport slave  : the arbiter's view (takes requests, drives memory)
//   modport master : the surrounding system's view (requesters + memory)
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if;

    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_done;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic        ls_unsign;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic        busy;

    modport slave (
        input  if_req, if_addr,
        output if_done, if_rdata,
        input  ls_req, ls_we, ls_size, ls_unsign, ls_addr, ls_wdata,
        output ls_done, ls_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output if_req, if_addr,
        input  if_done, if_rdata,
        output ls_req, ls_we, ls_size, ls_unsign, ls_addr, ls_wdata,
        input  ls_done, ls_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
// Combinational formatter for an assembled little-endian 32-bit word.
//   word   in  32  assembled bytes, byte 0 in bits 7:0
//   size   in   2  SZ_B / SZ_H / SZ_W (2'b11 handled as a word)
//   unsign in   1  1 = zero-extend, 0 = sign-extend byte and half results
//   result out 32  formatted load value
// ---------------------------------------------------------------------------
module load_extend
    import mem_arb_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        unsign,
    output logic [31:0] result
);

    // Pick the low byte/half/word and fill the upper bits with either zeros
    // or copies of the top bit of the selected field.
    always_comb begin
        result = word;
        case (size)
            SZ_B: begin
                result = {{24{word[7] & ~unsign}}, word[7:0]};
            end
            SZ_H: begin
                result = {{16{word[15] & ~unsign}}, word[15:0]};
            end
            default: begin
                result = word;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one byte-wide synchronous memory between a fetch requester (always
// 32-bit reads) and a load/store requester (byte/half/word, signed or
// unsigned loads). Multi-byte accesses are split into consecutive byte
// beats, little-endian, with the address wrapping inside the 256-byte space.
//   clk  in  1  rising-edge clock
//   rst  in  1  asynchronous, active-low reset
//   bus  slave modport of mem_port_arbiter_if:
//        if_req/if_addr -> if_done pulse, if_rdata held word
//        ls_req/ls_we/ls_size/ls_unsign/ls_addr/ls_wdata -> ls_done, ls_rdata
//        mem_en/mem_we/mem_addr/mem_wdata -> memory, mem_rdata <- memory
//        busy high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_t  state;
    arb_state_t  state_next;

    logic [2:0]  cnt;
    logic [2:0]  nbytes;
    logic        grant_ls;
    logic        last_ls;

    logic [7:0]  lat_addr;
    logic        lat_we;
    logic [1:0]  lat_size;
    logic        lat_unsign;
    logic [31:0] lat_wdata;

    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [31:0] ext_word;
    logic [31:0] if_rdata_q;
    logic [31:0] ls_rdata_q;

    logic        any_req;
    logic        pick_ls;
    logic        last_beat;
    logic        cap_en;
    logic [1:0]  cap_idx;

    logic        mem_en_c;
    logic        mem_we_c;
    logic [7:0]  mem_addr_c;
    logic [7:0]  mem_wdata_c;

    // Round-robin choice: load/store wins when it is the only requester or
    // when fetch was the last one served. last_ls resets high so that the
    // very first tie after reset goes to fetch.
    assign any_req   = bus.if_req | bus.ls_req;
    assign pick_ls   = bus.ls_req & (~bus.if_req | ~last_ls);
    assign last_beat = (cnt == (nbytes - 3'd1));

    // A read beat issued with counter value k returns its byte one cycle
    // later, when the counter already shows k+1; the final byte shows up in
    // CAPTURE. So the byte slot being filled is always (cnt - 1), and the
    // 2-bit wrap turns cnt=4 into slot 3.
    assign cap_en  = ~lat_we & (((state == ST_ACCESS) && (cnt != 3'd0)) ||
                                (state == ST_CAPTURE));
    assign cap_idx = cnt[1:0] - 2'd1;

    // Word being assembled this cycle, including the byte arriving now, so
    // the formatted result can be registered on the CAPTURE edge.
    always_comb begin
        asm_next = asm_q;
        if (cap_en) begin
            asm_next[{cap_idx, 3'b000} +: 8] = bus.mem_rdata;
        end
    end

    load_extend u_load_extend (
        .word   (asm_next),
        .size   (lat_size),
        .unsign (lat_unsign),
        .result (ext_word)
    );

    // FSM state register; reset drops straight back to IDLE, which also
    // aborts any transfer in flight without a completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic plus the memory strobes. Requests are only looked at
    // in IDLE; reads pass through CAPTURE to collect the last byte, writes
    // go straight to DONE. Memory controls are forced to zero outside ACCESS.
    always_comb begin
        state_next  = state;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = 8'h00;
        mem_wdata_c = 8'h00;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_en_c    = 1'b1;
                mem_we_c    = lat_we;
                mem_addr_c  = lat_addr + {5'b00000, cnt};
                mem_wdata_c = lat_wdata[{cnt[1:0], 3'b000} +: 8];
                if (last_beat) begin
                    state_next = lat_we ? ST_DONE : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Transfer datapath: latch the winning request on the grant edge, step
    // the beat counter through ACCESS, gather read bytes, and update only the
    // granted requester's read-data register when a read completes. Stores
    // never touch either read-data register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 3'd0;
            nbytes     <= NB_WORD;
            grant_ls   <= 1'b0;
            last_ls    <= 1'b1;
            lat_addr   <= 8'h00;
            lat_we     <= 1'b0;
            lat_size   <= SZ_W;
            lat_unsign <= 1'b0;
            lat_wdata  <= 32'h0;
            asm_q      <= 32'h0;
            if_rdata_q <= 32'h0;
            ls_rdata_q <= 32'h0;
        end else begin
            asm_q <= asm_next;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        cnt      <= 3'd0;
                        grant_ls <= pick_ls;
                        last_ls  <= pick_ls;
                        if (pick_ls) begin
                            lat_addr   <= bus.ls_addr;
                            lat_we     <= bus.ls_we;
                            lat_size   <= bus.ls_size;
                            lat_unsign <= bus.ls_unsign;
                            lat_wdata  <= bus.ls_wdata;
                            nbytes     <= byte_count(bus.ls_size);
                        end else begin
                            lat_addr   <= bus.if_addr;
                            lat_we     <= 1'b0;
                            lat_size   <= SZ_W;
                            lat_unsign <= 1'b0;
                            lat_wdata  <= 32'h0;
                            nbytes     <= NB_WORD;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 3'd1;
                end
                ST_CAPTURE: begin
                    if (grant_ls) begin
                        ls_rdata_q <= ext_word;
                    end else begin
                        if_rdata_q <= ext_word;
                    end
                end
                ST_DONE: begin
                    cnt <= 3'd0;
                end
                default: begin
                    cnt <= 3'd0;
                end
            endcase
        end
    end

    // Completion pulses go only to the requester that owns the transfer.
    assign bus.if_done   = (state == ST_DONE) & ~grant_ls;
    assign bus.ls_done   = (state == ST_DONE) &  grant_ls;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ls_rdata  = ls_rdata_q;
    assign bus.mem_en    = mem_en_c;
    assign bus.mem_we    = mem_we_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.mem_wdata = mem_wdata_c;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: none; address width fixed at 8 bits (256-byte space), data width fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 if_req  in  1  fetch requester; level request for a 32-bit read.
REQ-005 if_addr  in  8  fetch byte address.
REQ-006 if_done  out  1  one-cycle pulse: fetch access complete.
REQ-007 if_rdata  out  32  fetched word; valid while if_done=1, held until next fetch completes.
REQ-008 ls_req  in  1  load/store requester; level request.
REQ-009 ls_we  in  1  1=store, 0=load.
REQ-010 ls_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-011 ls_unsign  in  1  1=zero-extend, 0=sign-extend loads of byte and half.
REQ-012 ls_addr  in  8  load/store byte address.
REQ-013 ls_wdata  in  32  store data; bytes taken little-endian from bit 7:0 up.
REQ-014 ls_done  out  1  one-cycle pulse: load/store access complete.
REQ-015 ls_rdata  out  32  extended load result; valid while ls_done=1, held until next load completes.
REQ-016 mem_en  out  1  byte-memory access strobe.
REQ-017 mem_we  out  1  byte-memory write enable (qualified by mem_en).
REQ-018 mem_addr  out  8  byte-memory address.
REQ-019 mem_wdata  out  8  byte-memory write data.
REQ-020 mem_rdata  in  8  byte-memory read data; synchronous, valid the cycle after mem_en with mem_we=0.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states IDLE, ACCESS, CAPTURE, DONE; requests sampled only in IDLE.
REQ-023 IDLE: one requester asserting -> grant it; both asserting -> grant the one not served last (round-robin); grant latches addr, we, size, unsign, wdata; next state ACCESS, byte counter cnt=0.
REQ-024 Byte count N: byte 1, half 2, word 4; fetch always 4 with we=0.
REQ-025 ACCESS: mem_en=1, mem_we=latched we, mem_addr=(base+cnt) mod 256 (wrap at 255->0), mem_wdata=wdata byte cnt; cnt increments each cycle; stays N cycles.
REQ-026 After last ACCESS cycle: read -> CAPTURE (1 cycle, mem_en=0), write -> DONE.
REQ-027 Read byte i captured from mem_rdata in the cycle after it was issued, into assembly byte i.
REQ-028 DONE: 1 cycle; pulses done of the granted requester only; loads present rdata extended per size/unsign; next state IDLE (no grant in DONE).
REQ-029 Latency from grant edge to done cycle: read N+2 cycles, write N+1 cycles.
REQ-030 Requester keeps req and inputs stable until its done; inputs changed mid-transfer are ignored.
REQ-031 Store: ls_rdata not updated; if_rdata never affected by ls traffic.
REQ-032 Misaligned addresses permitted; no alignment fault.
REQ-033 mem_en, mem_we, mem_wdata zero outside ACCESS.

Reset
REQ-034 rst low: immediate return to IDLE, cnt=0, all outputs 0, if_rdata=ls_rdata=0, round-robin set so fetch wins first tie.
REQ-035 Reset mid-transfer aborts it; no done pulse; partial stores stay in memory.

Structure
REQ-036 Package mem_arb_pkg holds state enum, size codes (SZ_B, SZ_H, SZ_W), byte-count constants.
REQ-037 One sub-module, load_extend: combinational 32-bit assembly to byte/half/word with sign/zero extension.

Verification
REQ-038 Fetch word at 0x64 with memory 11,05,FF,00 -> if_done cycle 6 after grant edge, if_rdata=0x00FF0511.
REQ-039 Load byte signed at 0x66 (FF) -> ls_rdata=0xFFFFFFFF; unsigned -> 0x000000FF.
REQ-040 Store word 0xDEADBEEF at 0xFE -> bytes EF,BE,AD,DE at 0xFE,0xFF,0x00,0x01 (wrap), ls_done 5 cycles after grant.
REQ-041 if_req and ls_req both high from reset -> fetch served first, then load/store, then fetch again if both still high.
REQ-042 rst low during 3rd ACCESS cycle of word store -> busy=0 immediately, no ls_done, only first two bytes written.
